nibble_mem_responder: RTL

//  Memory-side responder for the 4-bit accumulator CPU bus (6-bit addr/wcyc out, 4-bit data in).

---
 rtl/nibble_bus_pkg.sv | 13 +
 rtl/nibble_mem_responder_if.sv | 12 +
 rtl/nibble_ram.sv | 20 ++
 rtl/nibble_mem_responder.sv | 102 ++++++++++
 4 files changed

// File: rtl/nibble_bus_pkg.sv
// Shared constants for the 4-bit accumulator CPU memory bus: widths, bus field
// positions and the responder FSM state encoding.
package nibble_bus_pkg;
  localparam int ADDR_W   = 6;
  localparam int DATA_W   = 4;
  localparam int DEPTH    = 1 << ADDR_W;
  localparam int BUS_W    = 7;
  localparam int BUS_WCYC = 6;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] LOAD    = 2'd1;
  localparam logic [1:0] RELEASE = 2'd2;
endpackage

// File: rtl/nibble_mem_responder_if.sv
// CPU-side memory bus between the accumulator CPU (master) and the memory responder (slave).
interface nibble_mem_responder_if;
  import nibble_bus_pkg::*;

  // No valid/ready: every cycle is a transfer. bus_in[BUS_WCYC]=0 is a read of
  // bus_in[ADDR_W-1:0] answered on bus_data in the same cycle; =1 is a store of bus_in[3:0].
  logic [BUS_W-1:0]  bus_in;
  logic [DATA_W-1:0] bus_data;

  modport master (output bus_in, input bus_data);
  modport slave  (input bus_in, output bus_data);
endinterface

// File: rtl/nibble_ram.sv
// DEPTH x DW flop array with one asynchronous read port and one synchronous write port.
module nibble_ram #(
  parameter int AW = 6,
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/nibble_mem_responder.sv
// Memory responder for the nibble CPU: combinational reads, history-addressed stores,
// and a host loader that holds the CPU in reset while streaming a program in.
module nibble_mem_responder
  import nibble_bus_pkg::*;
(
  input  logic               clk,
  input  logic               rst_p,
  nibble_mem_responder_if.slave bus,
  input  logic               ld_start,
  input  logic               ld_en,
  input  logic [DATA_W-1:0]  ld_data,
  input  logic               ld_done,
  output logic               cpu_hold,
  output logic               ld_wrap,
  output logic               wr_strobe,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [DATA_W-1:0]  wr_data,
  output logic [1:0]         state_dbg
);
  logic [1:0]               state, state_nxt;
  logic [ADDR_W-1:0]        ptr;
  logic [ADDR_W-DATA_W-1:0] hist1;
  logic [DATA_W-1:0]        hist0;

  logic                     idle, wcyc, rd_en, ld_wr, cpu_st;
  logic [ADDR_W-1:0]        st_addr, ram_waddr;
  logic [DATA_W-1:0]        ram_wdata, ram_rdata;

  assign idle    = (state == IDLE);
  assign wcyc    = bus.bus_in[BUS_WCYC];
  assign rd_en   = idle && !wcyc;
  // Only the low bits of the older nibble matter for the store address.
  assign st_addr = {hist1, hist0};

  // A load may begin with a write in the very cycle ld_start is seen; loader beats CPU.
  assign ld_wr   = !rst_p && ld_en && ((state == LOAD) || (idle && ld_start));
  assign cpu_st  = !rst_p && idle && wcyc && !cpu_hold && !ld_wr;

  assign ram_waddr = ld_wr ? (ld_start ? '0 : ptr) : st_addr;
  assign ram_wdata = ld_wr ? ld_data : bus.bus_in[DATA_W-1:0];

  nibble_ram #(.AW(ADDR_W), .DW(DATA_W)) u_ram (
    .clk   (clk),
    .we    (ld_wr || cpu_st),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (bus.bus_in[ADDR_W-1:0]),
    .rdata (ram_rdata)
  );

  assign bus.bus_data = rd_en ? ram_rdata : '0;
  assign state_dbg    = state;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ld_start) state_nxt = LOAD;
      LOAD:    if (!ld_start && ld_done) state_nxt = RELEASE;
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_p) begin
      state     <= IDLE;
      ptr       <= '0;
      hist1     <= '0;
      hist0     <= '0;
      cpu_hold  <= 1'b0;
      ld_wrap   <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
    end else begin
      state    <= state_nxt;
      cpu_hold <= (state_nxt != IDLE);

      if (ld_start && (state != RELEASE)) begin
        ptr     <= {{(ADDR_W-1){1'b0}}, ld_en};
        ld_wrap <= 1'b0;
      end else if ((state == LOAD) && ld_en) begin
        ptr <= ptr + 1'b1;
        if (ptr == '1) ld_wrap <= 1'b1;
      end

      if (state == RELEASE) begin
        hist1 <= '0;
        hist0 <= '0;
      end else if (rd_en) begin
        hist1 <= hist0[ADDR_W-DATA_W-1:0];
        hist0 <= bus.bus_data;
      end

      wr_strobe <= cpu_st;
      if (cpu_st) begin
        wr_addr <= st_addr;
        wr_data <= bus.bus_in[DATA_W-1:0];
      end
    end
  end
endmodule
